// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the EX-stage control and the
// multiply/divide unit: operands, op code and strobe in, handshake and the
// HI/LO architectural registers out.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [2:0]       op;
    logic             start;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Requester side (pipeline control / ALU).
    modport master (
        output in1, in2, op, start,
        input  busy, done, div_by_zero, hi, lo
    );

    // Responder side (the multiply/divide unit itself).
    modport slave (
        input  in1, in2, op, start,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS multiply/divide unit owning the HI/LO register pair.
// One bit per cycle: shift-add multiply over a 2*WIDTH accumulator and a
// restoring divide that reuses the same accumulator as {remainder, quotient}.
// Signed ops run on magnitudes; signs are re-applied in a single FIX cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_t;

    // Control and architectural state.
    state_t           state;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic             done_q;
    logic             dz_pulse_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    // Datapath state, loaded on accept.
    logic [2*WIDTH-1:0] acc;      // multiply: {partial, multiplier}; divide: {rem, quotient}
    logic [WIDTH-1:0]   opd;      // multiplicand or divisor magnitude
    logic               is_div;
    logic               res_neg;  // product/quotient sign
    logic               rem_neg;  // remainder follows the dividend
    logic               dz;       // divisor was zero at accept

    // Request decode and operand conditioning.
    op_t              req_op;
    logic             req_md;
    logic             req_div;
    logic             req_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             accept_md;

    // Per-iteration and fix-up results.
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Decode the incoming request and take operand magnitudes for signed ops.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        req_op     = op_t'(bus.op);
        req_md     = 1'b0;
        req_div    = 1'b0;
        req_signed = 1'b0;
        case (req_op)
            OP_MULT:  begin req_md = 1'b1; req_signed = 1'b1; end
            OP_MULTU: begin req_md = 1'b1; end
            OP_DIV:   begin req_md = 1'b1; req_div = 1'b1; req_signed = 1'b1; end
            OP_DIVU:  begin req_md = 1'b1; req_div = 1'b1; end
            default:  ;
        endcase
        a_neg     = req_signed & bus.in1[WIDTH-1];
        b_neg     = req_signed & bus.in2[WIDTH-1];
        a_mag     = a_neg ? (~bus.in1 + 1'b1) : bus.in1;
        b_mag     = b_neg ? (~bus.in2 + 1'b1) : bus.in2;
        accept_md = bus.start & (state == IDLE) & req_md;
    end

    // One shift-add / restoring-divide step, plus the sign fix-up of the result.
    always_comb begin
        mul_addend = acc[0] ? opd : {WIDTH{1'b0}};
        mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        mul_next   = {mul_sum, acc[WIDTH-1:1]};

        // Shift the next dividend bit into the remainder and trial-subtract;
        // the extra top bit is the borrow that selects restore vs keep.
        div_diff = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {2'b00, opd};
        if (!div_diff[WIDTH+1]) begin
            div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {acc[2*WIDTH-2:0], 1'b0};
        end

        prod_fix = res_neg ? (~acc + 1'b1) : acc;
        quo_fix  = res_neg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_fix  = rem_neg ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end

    // Datapath: load operands on accept, advance one bit per ITER cycle.
    // NOTE: these registers carry no reset; they are always loaded on accept before being read.
    always_ff @(posedge clock) begin
        if (accept_md) begin
            is_div  <= req_div;
            res_neg <= a_neg ^ b_neg;
            rem_neg <= a_neg;
            dz      <= req_div & (bus.in2 == {WIDTH{1'b0}});
            if (req_div) begin
                opd <= b_mag;
                acc <= {{WIDTH{1'b0}}, a_mag};
            end else begin
                opd <= a_mag;
                acc <= {{WIDTH{1'b0}}, b_mag};
            end
        end else if (state == ITER) begin
            acc <= is_div ? div_next : mul_next;
        end
    end

    // Control FSM with registered handshake outputs and the HI/LO registers.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dz_pulse_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q     <= 1'b0;
            dz_pulse_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (req_op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                cnt    <= '0;
                                busy_q <= 1'b1;
                                state  <= ITER;
                            end
                            OP_MTHI: hi_q <= bus.in1;
                            OP_MTLO: lo_q <= bus.in1;
                            default: ;
                        endcase
                    end
                end
                ITER: begin
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        if (dz) begin
                            dz_pulse_q <= 1'b1;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dz_pulse_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO results, handshake
// latency, divide-by-zero, ignored starts, mid-operation reset.
module tb_mult_div_unit;
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;
    logic [31:0] m_hi;   // model of HI
    logic [31:0] m_lo;   // model of LO

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge: present a request for one clock edge, then scramble operands.
    task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = o;
        bus.in1   = a;
        bus.in2   = b;
        @(negedge clock);
        bus.start = 1'b0;
        bus.op    = OP_NONE;
        bus.in1   = $urandom;
        bus.in2   = $urandom;
    endtask

    // Called in the cycle after the accept edge (elapsed = edges already past it).
    // Returns at the negedge of the done cycle.
    task automatic wait_done(input string tag, input int elapsed,
                             input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
        int busy_n = 0;
        int lat    = 0;
        bit seen   = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.done) begin
                seen = 1;
                lat  = i + 1;
                break;
            end
            if (bus.busy) busy_n++;
            if (i == 5) begin
                check({tag, " hi hold"}, bus.hi, m_hi);
                check({tag, " lo hold"}, bus.lo, m_lo);
            end
            @(negedge clock);
        end
        check({tag, " done seen"}, seen, 1);
        check({tag, " latency"}, lat, 34 - elapsed);
        check({tag, " busy cycles"}, busy_n, 33 - elapsed);
        check({tag, " busy at done"}, bus.busy, 0);
        check({tag, " div_by_zero"}, bus.div_by_zero, edz);
        check({tag, " hi"}, bus.hi, ehi);
        check({tag, " lo"}, bus.lo, elo);
        m_hi = ehi;
        m_lo = elo;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz);
        start_op(o, a, b);
        wait_done(tag, 0, ehi, elo, edz);
        @(negedge clock);
        check({tag, " done single"}, bus.done, 0);
        check({tag, " dz single"}, bus.div_by_zero, 0);
    endtask

    initial begin
        int dones;
        n_cmp = 0;
        n_bad = 0;
        m_hi  = '0;
        m_lo  = '0;
        bus.start = 1'b0;
        bus.op    = OP_NONE;
        bus.in1   = '0;
        bus.in2   = '0;
        reset     = 1'b1;
        repeat (3) @(negedge clock);
        check("reset hi", bus.hi, 0);
        check("reset lo", bus.lo, 0);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset dz", bus.div_by_zero, 0);
        reset = 1'b0;
        @(negedge clock);

        // Main function across operand patterns.
        run_op("mult shift", OP_MULT, 32'h3AAA1111, 32'h00002000, 32'h00000755, 32'h42222000, 1'b0);
        run_op("div neg", OP_DIV, -32'sd101, 32'd3, 32'hFFFFFFFE, 32'hFFFFFFDF, 1'b0);
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("mult m1m1", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0);
        run_op("multu max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);

        // MTHI/MTLO are single-cycle and never raise busy/done.
        start_op(OP_MTHI, 32'h1234, 32'hDEAD);
        check("mthi busy", bus.busy, 0);
        check("mthi done", bus.done, 0);
        check("mthi hi", bus.hi, 32'h1234);
        start_op(OP_MTLO, 32'h5678, 32'hBEEF);
        check("mtlo lo", bus.lo, 32'h5678);
        check("mtlo hi kept", bus.hi, 32'h1234);
        m_hi = 32'h1234;
        m_lo = 32'h5678;

        // op 0 and 7 have no effect.
        start_op(OP_RSVD, 32'hAAAA5555, 32'h3);
        start_op(OP_NONE, 32'h5555AAAA, 32'h3);
        check("nop busy", bus.busy, 0);
        check("nop hi", bus.hi, m_hi);
        check("nop lo", bus.lo, m_lo);

        // Divide by zero leaves HI/LO alone.
        run_op("div by zero", OP_DIV, 32'd55, 32'd0, 32'h1234, 32'h5678, 1'b1);

        // Start while busy is ignored; a start in the done cycle is taken.
        start_op(OP_MULT, 32'h00012345, 32'h00000100);
        repeat (9) @(negedge clock);
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.in1   = 32'd9;
        bus.in2   = 32'd3;
        @(negedge clock);
        bus.start = 1'b0;
        bus.op    = OP_NONE;
        wait_done("mult ignore", 10, 32'h0, 32'h01234500, 1'b0);
        start_op(OP_DIV, 32'd9, 32'd3);
        wait_done("div b2b", 0, 32'd0, 32'd3, 1'b0);
        @(negedge clock);
        check("div b2b done single", bus.done, 0);

        // Reset at k=15 of a MULT aborts it with no done pulse.
        start_op(OP_MULT, 32'd7, 32'd6);
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst busy", bus.busy, 0);
        check("midrst done", bus.done, 0);
        check("midrst hi", bus.hi, 0);
        check("midrst lo", bus.lo, 0);
        reset = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.done) dones++;
        end
        check("midrst no done", dones, 0);
        check("midrst hi after", bus.hi, 0);

        // Boundary values.
        run_op("div minint", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
        run_op("mult minint", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
